// File: rtl/led_blink_driver.sv
// led_blink_driver: plays timed LED blink sequences from trigger pulses, with one buffered follow-up request.
module led_blink_driver #(
    parameter int ON_CYCLES  = 6000000,
    parameter int OFF_CYCLES = 6000000,
    parameter int CNT_W      = 4,
    parameter bit ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [CNT_W-1:0] blinks,
    output logic             led,
    output logic             busy,
    output logic             done,
    output logic             dropped
);
    localparam int MAXC = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(MAXC) < 1 ? 1 : $clog2(MAXC);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    state_t           state, state_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic [CNT_W-1:0] rem, rem_n, pend, pend_n;
    logic             pend_v, pend_v_n, done_n, dropped_n, req, fin;
    assign req = trigger && blinks != '0;
    assign fin = state == OFF && tmr == '0 && rem == CNT_W'(1);
    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        rem_n     = rem;
        pend_n    = pend;
        pend_v_n  = pend_v;
        done_n    = 1'b0;
        dropped_n = 1'b0;
        case (state)
            IDLE: if (req) begin
                state_n = ON;
                tmr_n   = TW'(ON_CYCLES - 1);
                rem_n   = blinks;
            end
            ON: if (tmr == '0) begin
                state_n = OFF;
                tmr_n   = TW'(OFF_CYCLES - 1);
            end else tmr_n = tmr - 1'b1;
            OFF: if (tmr != '0) tmr_n = tmr - 1'b1;
            else if (!fin) begin
                state_n = ON;
                tmr_n   = TW'(ON_CYCLES - 1);
                rem_n   = rem - 1'b1;
            end else begin
                // finishing edge: chain straight into the buffered or just-arrived request
                done_n  = 1'b1;
                state_n = pend_v || req ? ON : IDLE;
                tmr_n   = TW'(ON_CYCLES - 1);
                rem_n   = pend_v ? pend : blinks;
                pend_v_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && req) begin
            if (pend_v) dropped_n = 1'b1;
            else if (!fin) begin
                pend_n   = blinks;
                pend_v_n = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tmr     <= '0;
            rem     <= '0;
            pend    <= '0;
            pend_v  <= 1'b0;
            led     <= ACTIVE_LOW;
            busy    <= 1'b0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            rem     <= rem_n;
            pend    <= pend_n;
            pend_v  <= pend_v_n;
            led     <= (state_n == ON) ^ ACTIVE_LOW;
            busy    <= state_n != IDLE;
            done    <= done_n;
            dropped <= dropped_n;
        end
    end
endmodule
